// File: rtl/kp_div_pkg.sv
// Shared types and parameter limits for the hex-keypad divider.
package kp_div_pkg;

  typedef enum logic [1:0] {
    ENT_A  = 2'd0,
    ENT_B  = 2'd1,
    DIV    = 2'd2,
    RESULT = 2'd3
  } kp_state_t;

  localparam int NDIG_MIN = 1;
  localparam int NDIG_MAX = 8;

endpackage

// File: rtl/div_restoring_seq.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// done is high in the cycle whose closing edge retires the last bit; quot/rem are valid then.
module div_restoring_seq #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_w;
  logic [W-1:0]  shift_w;
  logic [CW-1:0] iter_cnt;
  logic [W:0]    trial;
  logic [W:0]    diff;
  logic          qbit;
  logic [W-1:0]  rem_nxt;

  // shift_w holds unconsumed dividend bits above the quotient bits built so far
  always_comb begin
    trial   = {rem_w, shift_w[W-1]};
    diff    = trial - {1'b0, divisor};
    qbit    = ~diff[W];
    rem_nxt = qbit ? diff[W-1:0] : trial[W-1:0];
  end

  assign quot = {shift_w[W-2:0], qbit};
  assign rem  = rem_nxt;
  assign done = busy && (iter_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      iter_cnt <= '0;
      rem_w    <= '0;
      shift_w  <= '0;
    end else if (start) begin
      busy     <= 1'b1;
      iter_cnt <= CW'(W);
      rem_w    <= '0;
      shift_w  <= dividend;
    end else if (busy) begin
      rem_w    <= rem_nxt;
      shift_w  <= quot;
      iter_cnt <= iter_cnt - CW'(1);
      if (iter_cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/kp_divider_seq.sv
// Hex-keypad divider: collects A then B nibble by nibble, divides, holds the result.
//   state  | meaning
//   ENT_A  | collecting dividend nibbles
//   ENT_B  | collecting divisor nibbles (or one-cycle divide-by-zero bypass pending)
//   DIV    | iterative divider running, keys ignored
//   RESULT | quot/rem/div0 valid; next key starts a new A
module kp_divider_seq
  import kp_div_pkg::*;
#(
  parameter  int NDIG = 2,
  localparam int W    = 4 * NDIG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [3:0]   key_hex,
  input  logic         key_clr,
  output logic [W-1:0] a_val,
  output logic [W-1:0] b_val,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic [1:0]   state_dbg
);

  localparam int NW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (NDIG < NDIG_MIN || NDIG > NDIG_MAX) begin : g_bad_ndig
    $error("kp_divider_seq: NDIG out of range");
  end

  kp_state_t     state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, quot_q, quot_d, rem_q, rem_d;
  logic          div0_q, div0_d, pend_q, pend_d;
  logic          last_nib, core_start, core_rst, core_busy, core_done;
  logic [W-1:0]  core_quot, core_rem;

  assign core_rst = rst | key_clr;

  div_restoring_seq #(.W(W)) u_div (
    .clk      (clk),
    .rst      (core_rst),
    .start    (core_start),
    .dividend (a_q),
    .divisor  (b_q),
    .busy     (core_busy),
    .done     (core_done),
    .quot     (core_quot),
    .rem      (core_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ENT_A;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    div0_d     = div0_q;
    pend_d     = pend_q;
    core_start = 1'b0;
    last_nib   = (cnt_q == NW'(NDIG - 1));

    if (key_clr) begin
      state_d = ENT_A;
      cnt_d   = '0;
      a_d     = '0;
      b_d     = '0;
      quot_d  = '0;
      rem_d   = '0;
      div0_d  = 1'b0;
      pend_d  = 1'b0;
    end else begin
      unique case (state_q)
        ENT_A: begin
          if (key_valid) begin
            a_d = (a_q << 4) | W'(key_hex);
            if (last_nib) begin
              state_d = ENT_B;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + NW'(1);
            end
          end
        end
        ENT_B: begin
          if (pend_q) begin
            // divide-by-zero bypass: divider never starts
            state_d = RESULT;
            quot_d  = '1;
            rem_d   = a_q;
            div0_d  = 1'b1;
            pend_d  = 1'b0;
          end else if (key_valid) begin
            b_d = (b_q << 4) | W'(key_hex);
            if (last_nib) begin
              cnt_d = '0;
              if (b_d == '0) begin
                pend_d = 1'b1;
              end else begin
                core_start = 1'b1;
                state_d    = DIV;
              end
            end else begin
              cnt_d = cnt_q + NW'(1);
            end
          end
        end
        DIV: begin
          if (core_done) begin
            state_d = RESULT;
            quot_d  = core_quot;
            rem_d   = core_rem;
          end else if (!core_busy) begin
            state_d = ENT_A;
          end
        end
        RESULT: begin
          if (key_valid) begin
            div0_d = 1'b0;
            a_d    = W'(key_hex);
            b_d    = '0;
            if (NDIG == 1) begin
              state_d = ENT_B;
              cnt_d   = '0;
            end else begin
              state_d = ENT_A;
              cnt_d   = NW'(1);
            end
          end
        end
        default: state_d = ENT_A;
      endcase
    end
  end

  assign a_val     = a_q;
  assign b_val     = b_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign div0      = div0_q;
  assign busy      = (state_q == DIV);
  assign done      = (state_q == RESULT);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_kp_divider_seq.sv
// Bench for kp_divider_seq: NDIG=2 vector table, random operands vs. arithmetic model, NDIG=4 corner.
module tb_kp_divider_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        kv2, kc2, kv4, kc4;
  logic [3:0]  kh2, kh4;
  logic [7:0]  a2, b2, q2, r2;
  logic [15:0] a4, b4, q4, r4;
  logic        busy2, done2, d02, busy4, done4, d04;
  logic [1:0]  st2, st4;

  kp_divider_seq #(.NDIG(2)) dut2 (
    .clk(clk), .rst(rst), .key_valid(kv2), .key_hex(kh2), .key_clr(kc2),
    .a_val(a2), .b_val(b2), .quot(q2), .rem(r2),
    .busy(busy2), .done(done2), .div0(d02), .state_dbg(st2)
  );

  kp_divider_seq #(.NDIG(4)) dut4 (
    .clk(clk), .rst(rst), .key_valid(kv4), .key_hex(kh4), .key_clr(kc4),
    .a_val(a4), .b_val(b4), .quot(q4), .rem(r4),
    .busy(busy4), .done(done4), .div0(d04), .state_dbg(st4)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] last_q = 8'h00;
  logic [7:0] last_r = 8'h00;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       d0;
    int         lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press2(input logic [3:0] h);
    @(negedge clk); kv2 = 1'b1; kh2 = h;
    @(negedge clk); kv2 = 1'b0;
  endtask

  task automatic press4(input logic [3:0] h);
    @(negedge clk); kv4 = 1'b1; kh4 = h;
    @(negedge clk); kv4 = 1'b0;
  endtask

  task automatic chk_rst2(input string tag);
    chk({tag, "_a"}, a2, 0);
    chk({tag, "_b"}, b2, 0);
    chk({tag, "_q"}, q2, 0);
    chk({tag, "_r"}, r2, 0);
    chk({tag, "_busy"}, busy2, 0);
    chk({tag, "_done"}, done2, 0);
    chk({tag, "_div0"}, d02, 0);
    chk({tag, "_state"}, st2, 0);
  endtask

  // Called at the negedge right after the accepting edge of the last B nibble.
  task automatic wait2(output int lat, output int busy_n, output logic held);
    lat = 0; busy_n = 0; held = 1'b1;
    if (busy2) busy_n++;
    if (q2 !== last_q || r2 !== last_r) held = 1'b0;
    while (!done2 && lat < 64) begin
      @(negedge clk);
      lat++;
      if (busy2) busy_n++;
      if (!done2 && (q2 !== last_q || r2 !== last_r)) held = 1'b0;
    end
  endtask

  task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input logic ed0, input int elat, input string tag);
    int lat, bn;
    logic held;
    press2(a[7:4]); press2(a[3:0]);
    chk({tag, "_aval"}, a2, a);
    press2(b[7:4]); press2(b[3:0]);
    chk({tag, "_bval"}, b2, b);
    wait2(lat, bn, held);
    chk({tag, "_done"}, done2, 1);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_busy_cycles"}, bn, ed0 ? 0 : 8);
    chk({tag, "_hold"}, held, 1);
    chk({tag, "_quot"}, q2, eq);
    chk({tag, "_rem"}, r2, er);
    chk({tag, "_div0"}, d02, ed0);
    chk({tag, "_state"}, st2, 3);
    last_q = eq; last_r = er;
  endtask

  initial begin
    int lat, bn;
    logic held;
    logic [7:0] ra, rb, mq, mr;
    logic md0;

    vecs[0] = '{8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 8};
    vecs[1] = '{8'hC8, 8'h00, 8'hFF, 8'hC8, 1'b1, 1};
    vecs[2] = '{8'hFF, 8'h03, 8'h55, 8'h00, 1'b0, 8};
    vecs[3] = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 8};
    vecs[4] = '{8'h05, 8'hFF, 8'h00, 8'h05, 1'b0, 8};
    vecs[5] = '{8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 8};
    vecs[6] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 8};
    vecs[7] = '{8'h80, 8'h10, 8'h08, 8'h00, 1'b0, 8};

    rst = 1'b1; kv2 = 0; kc2 = 0; kh2 = 0; kv4 = 0; kc4 = 0; kh4 = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_rst2("reset");
    chk("reset4_state", st4, 0);
    chk("reset4_q", q4, 0);

    // NDIG=4: FFFF / 0001, then a new key in RESULT
    press4(4'hF); press4(4'hF); press4(4'hF); press4(4'hF);
    chk("n4_aval", a4, 16'hFFFF);
    chk("n4_state_entb", st4, 1);
    press4(4'h0); press4(4'h0); press4(4'h0); press4(4'h1);
    chk("n4_bval", b4, 16'h0001);
    lat = 0; bn = busy4 ? 1 : 0;
    while (!done4 && lat < 64) begin
      @(negedge clk); lat++;
      if (busy4) bn++;
    end
    chk("n4_busy_cycles", bn, 16);
    chk("n4_latency", lat, 16);
    chk("n4_quot", q4, 16'hFFFF);
    chk("n4_rem", r4, 16'h0000);
    chk("n4_div0", d04, 0);
    press4(4'h1);
    chk("n4_newkey_done", done4, 0);
    chk("n4_newkey_aval", a4, 16'h0001);
    chk("n4_newkey_bval", b4, 16'h0000);
    chk("n4_newkey_state", st4, 0);
    chk("n4_newkey_quot_hold", q4, 16'hFFFF);

    for (int i = 0; i < 8; i++)
      run2(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].d0, vecs[i].lat,
           $sformatf("vec%0d", i));

    // New key in RESULT keeps the previous result
    press2(4'h1);
    chk("newkey_done", done2, 0);
    chk("newkey_aval", a2, 8'h01);
    chk("newkey_bval", b2, 8'h00);
    chk("newkey_state", st2, 0);
    chk("newkey_quot_hold", q2, last_q);
    chk("newkey_rem_hold", r2, last_r);

    // key_clr with a simultaneous key after three nibbles
    press2(4'h2); press2(4'h3);
    chk("pre_clr_bval", b2, 8'h03);
    @(negedge clk); kc2 = 1'b1; kv2 = 1'b1; kh2 = 4'h4;
    @(negedge clk); kc2 = 1'b0; kv2 = 1'b0;
    chk_rst2("clr");
    last_q = 8'h00; last_r = 8'h00;
    run2(8'h64, 8'h0A, 8'h0A, 8'h00, 1'b0, 8, "after_clr");

    // Key pulsed during DIV is ignored
    press2(4'hF); press2(4'hF); press2(4'h0); press2(4'h3);
    @(negedge clk);
    press2(4'h5);
    wait2(lat, bn, held);
    chk("busykey_done", done2, 1);
    chk("busykey_bval", b2, 8'h03);
    chk("busykey_aval", a2, 8'hFF);
    chk("busykey_quot", q2, 8'h55);
    chk("busykey_rem", r2, 8'h00);
    last_q = 8'h55; last_r = 8'h00;

    // rst in the third DIV cycle aborts with no partial result
    press2(4'hC); press2(4'h8); press2(4'h0); press2(4'h7);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_rst2("divrst");
    repeat (12) @(negedge clk);
    chk("divrst_idle_state", st2, 0);
    chk("divrst_idle_quot", q2, 0);
    chk("divrst_idle_rem", r2, 0);
    last_q = 8'h00; last_r = 8'h00;
    run2(8'h5A, 8'h07, 8'h0C, 8'h06, 1'b0, 8, "after_rst");

    // Random operands against plain integer division
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i % 5 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if (rb == 0) begin
        mq = 8'hFF; mr = ra; md0 = 1'b1;
      end else begin
        mq = ra / rb; mr = ra % rb; md0 = 1'b0;
      end
      run2(ra, rb, mq, mr, md0, md0 ? 1 : 8, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kp_divider_seq.md
KP_DIVIDER_SEQ -- requirements
Module: kp_divider_seq

Interface
REQ-001 SHALL have parameter NDIG, default 2, meaning hex nibbles per operand (legal 1..8).
REQ-002 SHALL have derived localparam W = 4*NDIG, meaning operand/result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port key_valid, input, 1 bit: one-cycle pulse marking a new key.
REQ-006 SHALL have port key_hex, input, 4 bits: nibble value, sampled only when key_valid=1.
REQ-007 SHALL have port key_clr, input, 1 bit: synchronous soft-clear request.
REQ-008 SHALL have port a_val, output, W bits: dividend as entered.
REQ-009 SHALL have port b_val, output, W bits: divisor as entered.
REQ-010 SHALL have port quot, output, W bits: registered quotient.
REQ-011 SHALL have port rem, output, W bits: registered remainder.
REQ-012 SHALL have port busy, output, 1 bit: high while state=DIV.
REQ-013 SHALL have port done, output, 1 bit: high while state=RESULT.
REQ-014 SHALL have port div0, output, 1 bit: last result was divide-by-zero; valid while done=1.
REQ-015 SHALL have port state_dbg, output, 2 bits: current FSM state encoding.

Function
REQ-016 SHALL implement FSM states ENT_A=0, ENT_B=1, DIV=2, RESULT=3, plus a nibble counter 0..NDIG-1.
REQ-017 ENT_A/ENT_B: each accepted key SHALL shift the nibble into the operand LSB (MS nibble entered first), with NDIG-th nibble advancing ENT_A->ENT_B (counter cleared) or ENT_B->DIV/RESULT.
REQ-018 On the edge accepting the last B nibble with B!=0: SHALL enter DIV, load the working remainder to 0, the shifter to A, and the iteration counter to W.
REQ-019 DIV SHALL perform one restoring shift-subtract iteration per cycle (MSB first), with quot/rem registered and state entering RESULT on the W-th edge after the entry edge.
REQ-020 Divide-by-zero (B==0 at last nibble) SHALL skip DIV, with next edge giving RESULT, quot = all ones, rem = A, div0=1.
REQ-021 key_valid during DIV SHALL be ignored (no operand, counter or state change).
REQ-022 key_valid in RESULT SHALL clear done/div0, zero a_val and b_val, load key_hex as A MS nibble (a_val = key_hex), set counter=1 and go to ENT_A, with quot/rem held until the next result.
REQ-023 If NDIG=1, REQ-022 SHALL go directly to ENT_B.
REQ-024 key_clr in any state SHALL have the same effect as rst on the next edge, and SHALL take precedence over a simultaneous key_valid.
REQ-025 quot and rem SHALL change only on the result edge (REQ-019/020); a_val and b_val SHALL reflect entered nibbles immediately after each accept edge.
REQ-026 Arithmetic: results SHALL be exact unsigned integers, with A = quot*B + rem and rem < B for all B != 0.

Reset
REQ-027 On rst=1 at a rising edge, the block SHALL set state=ENT_A, counters=0, a_val=b_val=quot=rem=0, and busy=done=div0=0.
REQ-028 rst asserted during DIV SHALL abort the division with no partial result appearing on quot/rem.

Structure
REQ-029 Package kp_div_pkg SHALL hold the state enum (kp_state_t) and the NDIG range check constants.
REQ-030 The iterative datapath SHALL be sub-module div_restoring_seq (parameter W; start/busy/done handshake; ports dividend, divisor, quot, rem).
REQ-031 Top-level SHALL contain only key capture, the FSM, and the div0 bypass.

Verification
REQ-032 NDIG=2: keys C,8,0,7 -> a_val=0xC8, b_val=0x07; done 8 cycles after the 4th key; quot=0x1C, rem=0x04, div0=0.
REQ-033 NDIG=2: keys C,8,0,0 -> done 1 cycle after the 4th key; quot=0xFF, rem=0xC8, div0=1, busy never high.
REQ-034 NDIG=2: keys F,F,0,3, then key 5 pulsed during busy -> quot=0x55, rem=0x00, and the extra key is ignored (b_val stays 0x03).
REQ-035 NDIG=4: 0xFFFF / 0x0001 -> busy exactly 16 cycles, quot=0xFFFF, rem=0x0000; then key 1 in RESULT -> done=0, a_val=0x0001, state ENT_A, and quot holds 0xFFFF.
REQ-036 key_clr together with key_valid after 3 nibbles, and separately rst at cycle 3 of DIV -> all outputs return to their reset values (REQ-027) and the next 4 keys complete a fresh division.
